demux_tdm: RTL and testbench

DEMUX_TDM -- requirements
Module: demux_tdm

---
 rtl/demux_tdm.sv | 113 +++++++++++
 tb/tb_demux_tdm.sv | 304 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/demux_tdm.sv
// Four-lane TDM serial demultiplexer: routes each accepted bit round-robin to a lane
// shift register and presents completed MSB-first words with a one-cycle valid pulse.
module demux_tdm #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             din,
    input  logic             din_valid,
    input  logic             frame_sync,
    input  logic             err_clr,
    output logic [WIDTH-1:0] dout0,
    output logic [WIDTH-1:0] dout1,
    output logic [WIDTH-1:0] dout2,
    output logic [WIDTH-1:0] dout3,
    output logic             vld0,
    output logic             vld1,
    output logic             vld2,
    output logic             vld3,
    output logic [1:0]       slot,
    output logic             sync_err
);

    localparam int unsigned CW = $clog2(WIDTH);
    // The final bit of a word goes straight into dout, so only WIDTH-1 bits are stored.
    localparam int unsigned SW = WIDTH - 1;
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

    logic [1:0]       slot_q, slot_d;
    logic [SW-1:0]    sr_q   [4];
    logic [SW-1:0]    sr_d   [4];
    logic [CW-1:0]    cnt_q  [4];
    logic [CW-1:0]    cnt_d  [4];
    logic [WIDTH-1:0] dout_q [4];
    logic [WIDTH-1:0] dout_d [4];
    logic [3:0]       vld_q, vld_d;
    logic             err_q, err_d;

    logic             misalign;
    logic [WIDTH-1:0] shifted;

    always_comb begin
        slot_d   = slot_q;
        sr_d     = sr_q;
        cnt_d    = cnt_q;
        dout_d   = dout_q;
        vld_d    = '0;
        err_d    = err_q;
        misalign = din_valid && frame_sync && (slot_q != 2'd0);
        shifted  = {sr_q[slot_q], din};

        if (misalign) begin
            // Realign: drop every partial word and restart the frame on this bit.
            for (int i = 0; i < 4; i++) begin
                sr_d[i]  = '0;
                cnt_d[i] = '0;
            end
            sr_d[0]  = SW'(din);
            cnt_d[0] = CW'(1);
            slot_d   = 2'd1;
        end else if (din_valid) begin
            sr_d[slot_q] = shifted[SW-1:0];
            if (cnt_q[slot_q] == LAST) begin
                dout_d[slot_q] = shifted;
                vld_d[slot_q]  = 1'b1;
                cnt_d[slot_q]  = '0;
            end else begin
                cnt_d[slot_q] = cnt_q[slot_q] + CW'(1);
            end
            slot_d = slot_q + 2'd1;
        end

        if (misalign) begin
            err_d = 1'b1;
        end else if (err_clr) begin
            err_d = 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            slot_q <= '0;
            vld_q  <= '0;
            err_q  <= 1'b0;
            for (int i = 0; i < 4; i++) begin
                sr_q[i]   <= '0;
                cnt_q[i]  <= '0;
                dout_q[i] <= '0;
            end
        end else begin
            slot_q <= slot_d;
            vld_q  <= vld_d;
            err_q  <= err_d;
            for (int i = 0; i < 4; i++) begin
                sr_q[i]   <= sr_d[i];
                cnt_q[i]  <= cnt_d[i];
                dout_q[i] <= dout_d[i];
            end
        end
    end

    assign dout0    = dout_q[0];
    assign dout1    = dout_q[1];
    assign dout2    = dout_q[2];
    assign dout3    = dout_q[3];
    assign vld0     = vld_q[0];
    assign vld1     = vld_q[1];
    assign vld2     = vld_q[2];
    assign vld3     = vld_q[3];
    assign slot     = slot_q;
    assign sync_err = err_q;

endmodule

// File: tb/tb_demux_tdm.sv
// Self-checking bench for demux_tdm: directed frames plus randomized traffic compared
// against a queue-based lane model.
module tb_demux_tdm;

    localparam int unsigned WIDTH = 8;
    localparam int unsigned VW    = 4 * WIDTH + 7;

    logic             clk = 1'b0;
    logic             rst_n = 1'b1;
    logic             din = 1'b0;
    logic             din_valid = 1'b0;
    logic             frame_sync = 1'b0;
    logic             err_clr = 1'b0;
    logic [WIDTH-1:0] dout0, dout1, dout2, dout3;
    logic             vld0, vld1, vld2, vld3;
    logic [1:0]       slot;
    logic             sync_err;

    demux_tdm #(.WIDTH(WIDTH)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
        .din        (din),
        .din_valid  (din_valid),
        .frame_sync (frame_sync),
        .err_clr    (err_clr),
        .dout0      (dout0),
        .dout1      (dout1),
        .dout2      (dout2),
        .dout3      (dout3),
        .vld0       (vld0),
        .vld1       (vld1),
        .vld2       (vld2),
        .vld3       (vld3),
        .slot       (slot),
        .sync_err   (sync_err)
    );

    always #5 clk = ~clk;

    wire [VW-1:0]    obs = {dout3, dout2, dout1, dout0, vld3, vld2, vld1, vld0, slot, sync_err};
    wire [3:0]       obs_vld = {vld3, vld2, vld1, vld0};
    wire [WIDTH-1:0] obs_dout [4];
    assign obs_dout[0] = dout0;
    assign obs_dout[1] = dout1;
    assign obs_dout[2] = dout2;
    assign obs_dout[3] = dout3;

    int n_checks = 0;
    int n_pass   = 0;

    // Reference model: each lane collects its bits in a queue; a full queue is a word.
    bit               lane_bits [4][$];
    logic [WIDTH-1:0] m_dout [4];
    logic [3:0]       m_vld;
    int               m_slot;
    logic             m_err;

    logic [WIDTH-1:0] frame_bytes [4];
    logic [WIDTH-1:0] cur_bytes [4];

    function automatic logic [VW-1:0] model_vec();
        return {m_dout[3], m_dout[2], m_dout[1], m_dout[0], m_vld, 2'(m_slot), m_err};
    endfunction

    // Bit k of a 32-bit frame: lane k mod 4, MSB-first position k / 4.
    function automatic bit stream_bit(int k);
        logic [WIDTH-1:0] b;
        b = cur_bytes[k % 4];
        return b[WIDTH - 1 - k / 4];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < 4; i++) begin
            lane_bits[i].delete();
            m_dout[i] = '0;
        end
        m_vld  = '0;
        m_slot = 0;
        m_err  = 1'b0;
    endtask

    task automatic model_step(input bit d, input bit v, input bit fs, input bit clr);
        bit               set;
        int               lane;
        logic [WIDTH-1:0] word;
        set   = 1'b0;
        m_vld = '0;
        if (v) begin
            if (fs && m_slot != 0) begin
                for (int i = 0; i < 4; i++) lane_bits[i].delete();
                lane_bits[0].push_back(d);
                m_slot = 1;
                set    = 1'b1;
            end else begin
                lane = m_slot;
                lane_bits[lane].push_back(d);
                if (lane_bits[lane].size() == WIDTH) begin
                    word = '0;
                    for (int k = 0; k < WIDTH; k++)
                        word = (word << 1) | WIDTH'(lane_bits[lane][k]);
                    m_dout[lane] = word;
                    m_vld[lane]  = 1'b1;
                    lane_bits[lane].delete();
                end
                m_slot = (m_slot + 1) % 4;
            end
        end
        if (set) m_err = 1'b1;
        else if (clr) m_err = 1'b0;
    endtask

    // Drive one cycle of inputs, clock it, update the model, sample 1 ns later.
    task automatic step(input bit d, input bit v, input bit fs, input bit clr);
        din        = d;
        din_valid  = v;
        frame_sync = fs;
        err_clr    = clr;
        @(posedge clk);
        model_step(d, v, fs, clr);
        #1;
    endtask

    task automatic test_reset();
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== '0) $display("FAIL reset_outputs: got %h, expected 0", obs);
        else n_pass++;
        n_checks++;
        if (slot !== 2'd0) $display("FAIL reset_slot: got %0d, expected 0", slot);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        step(1'b0, 1'b0, 1'b0, 1'b0);
    endtask

    task automatic test_stream();
        logic [3:0] ev;
        cur_bytes = frame_bytes;
        for (int k = 0; k < 32; k++) begin
            step(stream_bit(k), 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== model_vec())
                $display("FAIL stream bit %0d: got %h, expected %h", k, obs, model_vec());
            else n_pass++;
            if (k >= 28) begin
                ev = 4'b0001 << (k - 28);
                n_checks++;
                if (obs_vld !== ev || obs_dout[k-28] !== frame_bytes[k-28])
                    $display("FAIL stream_word lane %0d: got vld %b dout %h, expected vld %b dout %h",
                             k - 28, obs_vld, obs_dout[k-28], ev, frame_bytes[k-28]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_gapped();
        cur_bytes = frame_bytes;
        for (int k = 0; k < 32; k++) begin
            step(stream_bit(k), 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== model_vec())
                $display("FAIL gapped bit %0d: got %h, expected %h", k, obs, model_vec());
            else n_pass++;
            for (int g = 0; g < 3; g++) begin
                // frame_sync without din_valid must be ignored.
                step(1'($urandom), 1'b0, 1'($urandom), 1'b0);
                n_checks++;
                if (obs !== model_vec())
                    $display("FAIL gapped idle %0d.%0d: got %h, expected %h",
                             k, g, obs, model_vec());
                else n_pass++;
            end
        end
        for (int l = 0; l < 4; l++) begin
            n_checks++;
            if (obs_dout[l] !== frame_bytes[l])
                $display("FAIL gapped_dout lane %0d: got %h, expected %h",
                         l, obs_dout[l], frame_bytes[l]);
            else n_pass++;
        end
    endtask

    task automatic test_aligned_sync();
        for (int f = 0; f < 2; f++) begin
            if (f == 0) cur_bytes = frame_bytes;
            else for (int l = 0; l < 4; l++) cur_bytes[l] = WIDTH'($urandom);
            for (int k = 0; k < 32; k++) begin
                step(stream_bit(k), 1'b1, k == 0, 1'b0);
                n_checks++;
                if (obs !== model_vec() || sync_err !== 1'b0)
                    $display("FAIL aligned frame %0d bit %0d: got %h, expected %h",
                             f, k, obs, model_vec());
                else n_pass++;
            end
            for (int l = 0; l < 4; l++) begin
                n_checks++;
                if (obs_dout[l] !== cur_bytes[l])
                    $display("FAIL aligned_dout frame %0d lane %0d: got %h, expected %h",
                             f, l, obs_dout[l], cur_bytes[l]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_misaligned_sync();
        cur_bytes = frame_bytes;
        for (int k = 0; k < 10; k++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        n_checks++;
        if (slot !== 2'd2) $display("FAIL misalign_pre_slot: got %0d, expected 2", slot);
        else n_pass++;
        step(stream_bit(0), 1'b1, 1'b1, 1'b0);
        n_checks++;
        if (sync_err !== 1'b1 || slot !== 2'd1 || obs_vld !== 4'b0000)
            $display("FAIL misalign_edge: got err %b slot %0d vld %b, expected err 1 slot 1 vld 0000",
                     sync_err, slot, obs_vld);
        else n_pass++;
        for (int k = 1; k < 32; k++) begin
            step(stream_bit(k), 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== model_vec())
                $display("FAIL misalign bit %0d: got %h, expected %h", k, obs, model_vec());
            else n_pass++;
        end
        for (int l = 0; l < 4; l++) begin
            n_checks++;
            if (obs_dout[l] !== frame_bytes[l])
                $display("FAIL misalign_dout lane %0d: got %h, expected %h",
                         l, obs_dout[l], frame_bytes[l]);
            else n_pass++;
        end
        for (int k = 0; k < 5; k++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        step(1'b1, 1'b1, 1'b1, 1'b1);
        n_checks++;
        if (sync_err !== 1'b1) $display("FAIL set_beats_clear: got %b, expected 1", sync_err);
        else n_pass++;
        step(1'b0, 1'b0, 1'b0, 1'b1);
        n_checks++;
        if (sync_err !== 1'b0 || obs !== model_vec())
            $display("FAIL err_clear: got %h, expected %h", obs, model_vec());
        else n_pass++;
    endtask

    task automatic test_reset_midword();
        logic [3:0] ev;
        for (int k = 0; k < 13; k++) step(1'($urandom), 1'b1, 1'b0, 1'b0);
        #3;
        rst_n = 1'b0;
        model_reset();
        #1;
        n_checks++;
        if (obs !== '0) $display("FAIL midword_reset: got %h, expected 0", obs);
        else n_pass++;
        #1;
        rst_n = 1'b1;
        cur_bytes = frame_bytes;
        for (int k = 0; k < 32; k++) begin
            step(stream_bit(k), 1'b1, 1'b0, 1'b0);
            n_checks++;
            if (obs !== model_vec())
                $display("FAIL post_reset bit %0d: got %h, expected %h", k, obs, model_vec());
            else n_pass++;
            if (k >= 28) begin
                ev = 4'b0001 << (k - 28);
                n_checks++;
                if (obs_vld !== ev || obs_dout[k-28] !== frame_bytes[k-28])
                    $display("FAIL post_reset_word lane %0d: got vld %b dout %h, expected vld %b dout %h",
                             k - 28, obs_vld, obs_dout[k-28], ev, frame_bytes[k-28]);
                else n_pass++;
            end
        end
    endtask

    task automatic test_random();
        for (int c = 0; c < 600; c++) begin
            step(1'($urandom), $urandom_range(0, 3) != 0, $urandom_range(0, 15) == 0,
                 $urandom_range(0, 7) == 0);
            n_checks++;
            if (obs !== model_vec() || $countones(obs_vld) > 1)
                $display("FAIL random cycle %0d: got %h, expected %h", c, obs, model_vec());
            else n_pass++;
        end
    endtask

    initial begin
        frame_bytes[0] = 8'hA5;
        frame_bytes[1] = 8'h3C;
        frame_bytes[2] = 8'hFF;
        frame_bytes[3] = 8'h01;
        model_reset();
        test_reset();
        test_stream();
        test_gapped();
        test_aligned_sync();
        test_misaligned_sync();
        test_reset_midword();
        test_random();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
